// File: rtl/mem_resp_unit_4b.sv
`default_nettype none
// ============================================================================
// Module   : mem_resp_unit_4b
// Brief    : Word-organized memory responder for the 4B memory-message channel.
// Revision : 1.0  initial release
// ============================================================================

package mem_msg_4b_pkg;
  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;
endpackage

module mem_resp_unit_4b
  import mem_msg_4b_pkg::*;
#(
  parameter int NUM_WORDS = 1024,
  parameter int LATENCY   = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  input  mem_req_4B_t  memreq_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy,
  output mem_resp_4B_t memresp_msg
);

  localparam int         c_idx_w      = $clog2(NUM_WORDS);
  localparam logic [3:0] c_latency    = 4'(LATENCY);
  localparam logic [2:0] c_type_read  = 3'd0;
  localparam logic [2:0] c_type_write = 3'd1;
  localparam logic [2:0] c_type_init  = 3'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;
  mem_resp_4B_t r_resp;
  logic [31:0]  r_mem [NUM_WORDS];

  logic               w_req_fire;
  logic               w_resp_fire;
  logic               w_is_write;
  logic [c_idx_w-1:0] w_idx;
  logic [1:0]         w_off;
  logic [3:0]         w_size_mask;
  logic [3:0]         w_byte_en;
  logic [31:0]        w_rmask;
  logic [31:0]        w_word;
  logic [31:0]        w_rdata;
  logic [31:0]        w_wdata;
  logic               w_unused_addr;

  assign memreq_rdy  = (r_state == S_IDLE);
  assign memresp_val = (r_state == S_RESP);
  assign memresp_msg = r_resp;

  assign w_req_fire  = memreq_val & memreq_rdy;
  assign w_resp_fire = memresp_val & memresp_rdy;
  assign w_is_write  = (memreq_msg.type_ == c_type_write) ||
                       (memreq_msg.type_ == c_type_init);

  // Upper address bits are ignored so the address space wraps.
  assign w_idx         = memreq_msg.addr[2 +: c_idx_w];
  assign w_off         = memreq_msg.addr[1:0];
  assign w_unused_addr = ^memreq_msg.addr[31:2+c_idx_w];

  always_comb begin
    w_size_mask = 4'b1111;
    w_rmask     = 32'hFFFF_FFFF;
    case (memreq_msg.len)
      2'd1: begin w_size_mask = 4'b0001; w_rmask = 32'h0000_00FF; end
      2'd2: begin w_size_mask = 4'b0011; w_rmask = 32'h0000_FFFF; end
      2'd3: begin w_size_mask = 4'b0111; w_rmask = 32'h00FF_FFFF; end
      default: ;
    endcase
  end

  // Lanes shifted past byte 3 fall off the top: no cross-word access.
  assign w_byte_en = w_size_mask << w_off;
  assign w_word    = r_mem[w_idx];
  assign w_rdata   = (w_word >> {w_off, 3'b000}) & w_rmask;
  assign w_wdata   = memreq_msg.data << {w_off, 3'b000};

  // Storage is deliberately not reset; an accepted write commits at accept.
  always_ff @(posedge clk) begin
    if (w_req_fire && w_is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byte_en[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req_fire) begin
          w_cnt_nxt = c_latency;
          if (c_latency == 4'd0) begin
            w_state_nxt = S_RESP;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (w_resp_fire) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_resp  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_req_fire) begin
        r_resp.type_  <= memreq_msg.type_;
        r_resp.opaque <= memreq_msg.opaque;
        r_resp.test   <= 2'd0;
        r_resp.len    <= memreq_msg.len;
        r_resp.data   <= (memreq_msg.type_ == c_type_read) ? w_rdata : 32'd0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_resp_unit_4b.sv
`default_nettype none
// Bench for mem_resp_unit_4b: directed scenarios plus randomized traffic
// checked against a byte-addressed reference memory.
module tb_mem_resp_unit_4b;
  import mem_msg_4b_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic [1:0]               req_val;
  logic [1:0]               req_rdy;
  mem_req_4B_t  [1:0]       req_msg;
  logic [1:0]               resp_val;
  logic [1:0]               resp_rdy;
  mem_resp_4B_t [1:0]       resp_msg;

  int n_pass  = 0;
  int n_total = 0;

  // Reference memory: one byte array per DUT, indexed by address modulo 4 KiB.
  logic [7:0] mm [2][4096];

  always #5 clk = ~clk;

  mem_resp_unit_4b #(.NUM_WORDS(1024), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .memreq_val(req_val[0]), .memreq_rdy(req_rdy[0]), .memreq_msg(req_msg[0]),
    .memresp_val(resp_val[0]), .memresp_rdy(resp_rdy[0]), .memresp_msg(resp_msg[0])
  );

  mem_resp_unit_4b #(.NUM_WORDS(1024), .LATENCY(3)) dut3 (
    .clk(clk), .reset(reset),
    .memreq_val(req_val[1]), .memreq_rdy(req_rdy[1]), .memreq_msg(req_msg[1]),
    .memresp_val(resp_val[1]), .memresp_rdy(resp_rdy[1]), .memresp_msg(resp_msg[1])
  );

  function automatic mem_req_4B_t mk(input logic [2:0] t, input logic [7:0] o,
                                     input logic [31:0] a, input logic [1:0] l,
                                     input logic [31:0] dat);
    mem_req_4B_t m;
    m.type_ = t; m.opaque = o; m.addr = a; m.len = l; m.data = dat;
    return m;
  endfunction

  // Applies one request to the byte model and returns the read data (0 otherwise).
  function automatic logic [31:0] model_access(input int d, input mem_req_4B_t m);
    int          a;
    int          off;
    int          sz;
    logic [31:0] res;
    a   = int'(m.addr[11:0]);
    off = int'(m.addr[1:0]);
    sz  = (m.len == 2'd0) ? 4 : int'(m.len);
    res = 32'd0;
    for (int k = 0; k < sz; k++) begin
      if (off + k < 4) begin
        if (m.type_ == 3'd0)
          res[8*k +: 8] = mm[d][a + k];
        else if (m.type_ == 3'd1 || m.type_ == 3'd2)
          mm[d][a + k] = m.data[8*k +: 8];
      end
    end
    return res;
  endfunction

  function automatic mem_resp_4B_t model_resp(input int d, input mem_req_4B_t m);
    mem_resp_4B_t r;
    r.type_  = m.type_;
    r.opaque = m.opaque;
    r.test   = 2'd0;
    r.len    = m.len;
    r.data   = model_access(d, m);
    return r;
  endfunction

  // One full transaction; lat counts cycles from accept edge to visible response.
  task automatic send(input int d, input mem_req_4B_t m, output mem_resp_4B_t r,
                      output int lat, output bit rdy_low);
    int guard;
    r = '0; lat = 999; rdy_low = 1'b1;
    req_msg[d] = m; req_val[d] = 1'b1; resp_rdy[d] = 1'b0;
    guard = 0;
    while (req_rdy[d] !== 1'b1 && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    req_val[d] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (resp_val[d] === 1'b1) begin
        lat = c; r = resp_msg[d];
        break;
      end
      if (req_rdy[d] !== 1'b0) rdy_low = 1'b0;
      @(posedge clk); #1;
    end
    if (req_rdy[d] !== 1'b0) rdy_low = 1'b0;
    resp_rdy[d] = 1'b1;
    @(posedge clk); #1;
    resp_rdy[d] = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_total++; if (req_rdy[d] !== 1'b1) $display("FAIL reset_rdy[%0d]: got %b want 1", d, req_rdy[d]); else n_pass++;
      n_total++; if (resp_val[d] !== 1'b0) $display("FAIL reset_val[%0d]: got %b want 0", d, resp_val[d]); else n_pass++;
      n_total++; if (resp_msg[d] !== '0) $display("FAIL reset_msg[%0d]: got %h want 0", d, resp_msg[d]); else n_pass++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_l0();
    mem_req_4B_t  m;
    mem_resp_4B_t r, e;
    int           lat;
    bit           rl;
    m = mk(3'd2, 8'h11, 32'h100, 2'd0, 32'hDEADBEEF);
    e = model_resp(0, m);
    send(0, m, r, lat, rl);
    n_total++; if (r !== e) $display("FAIL l0_init_resp: got %h want %h", r, e); else n_pass++;
    n_total++; if (r.data !== 32'd0) $display("FAIL l0_init_data: got %h want 0", r.data); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL l0_init_lat: got %0d want 1", lat); else n_pass++;
    n_total++; if (req_rdy[0] !== 1'b1) $display("FAIL l0_rdy_after_fire: got %b want 1", req_rdy[0]); else n_pass++;
    m = mk(3'd0, 8'h22, 32'h100, 2'd0, 32'h0);
    e = model_resp(0, m);
    send(0, m, r, lat, rl);
    n_total++; if (r !== e) $display("FAIL l0_read_resp: got %h want %h", r, e); else n_pass++;
    n_total++; if (r.data !== 32'hDEADBEEF || r.opaque !== 8'h22 || r.type_ !== 3'd0)
      $display("FAIL l0_read_fields: got %h want data deadbeef opaque 22 type 0", r); else n_pass++;
    n_total++; if (lat !== 1) $display("FAIL l0_read_lat: got %0d want 1", lat); else n_pass++;
  endtask

  task automatic test_latency();
    mem_req_4B_t  m;
    mem_resp_4B_t r, e;
    int           lat;
    bit           rl;
    m = mk(3'd1, 8'h33, 32'h40, 2'd0, 32'h11223344);
    e = model_resp(1, m);
    send(1, m, r, lat, rl);
    n_total++; if (r !== e) $display("FAIL l3_write_resp: got %h want %h", r, e); else n_pass++;
    n_total++; if (lat !== 4) $display("FAIL l3_write_lat: got %0d want 4", lat); else n_pass++;
    n_total++; if (rl !== 1'b1) $display("FAIL l3_write_rdy_low: got %b want 1", rl); else n_pass++;
    m = mk(3'd0, 8'h44, 32'h40, 2'd0, 32'h0);
    e = model_resp(1, m);
    send(1, m, r, lat, rl);
    n_total++; if (r.data !== 32'h11223344) $display("FAIL l3_read_data: got %h want 11223344", r.data); else n_pass++;
    n_total++; if (r !== e) $display("FAIL l3_read_resp: got %h want %h", r, e); else n_pass++;
    n_total++; if (lat !== 4) $display("FAIL l3_read_lat: got %0d want 4", lat); else n_pass++;
    n_total++; if (rl !== 1'b1) $display("FAIL l3_read_rdy_low: got %b want 1", rl); else n_pass++;
  endtask

  task automatic test_subword();
    mem_req_4B_t  m;
    mem_resp_4B_t r, e;
    int           lat;
    bit           rl;
    m = mk(3'd2, 8'h01, 32'h80, 2'd0, 32'hAABBCCDD);
    e = model_resp(0, m); send(0, m, r, lat, rl);
    m = mk(3'd1, 8'h02, 32'h81, 2'd1, 32'h00000055);
    e = model_resp(0, m); send(0, m, r, lat, rl);
    n_total++; if (r !== e) $display("FAIL sub_write_resp: got %h want %h", r, e); else n_pass++;
    m = mk(3'd0, 8'h03, 32'h80, 2'd0, 32'h0);
    e = model_resp(0, m); send(0, m, r, lat, rl);
    n_total++; if (r.data !== 32'hAABB55DD) $display("FAIL sub_read_word: got %h want aabb55dd", r.data); else n_pass++;
    m = mk(3'd0, 8'h04, 32'h82, 2'd2, 32'h0);
    e = model_resp(0, m); send(0, m, r, lat, rl);
    n_total++; if (r.data !== 32'h0000AABB) $display("FAIL sub_read_half: got %h want 0000aabb", r.data); else n_pass++;
    n_total++; if (r !== e) $display("FAIL sub_read_resp: got %h want %h", r, e); else n_pass++;
  endtask

  task automatic test_backpressure();
    mem_req_4B_t  m, m2;
    mem_resp_4B_t r, e, e2;
    int           lat;
    bit           rl;
    m = mk(3'd2, 8'h10, 32'h200, 2'd0, 32'h0BADCAFE);
    e = model_resp(0, m); send(0, m, r, lat, rl);
    m  = mk(3'd0, 8'h5A, 32'h200, 2'd0, 32'h0);
    e  = model_resp(0, m);
    m2 = mk(3'd0, 8'hA5, 32'h202, 2'd2, 32'h0);
    e2 = model_resp(0, m2);
    req_msg[0] = m; req_val[0] = 1'b1; resp_rdy[0] = 1'b0;
    @(posedge clk); #1;
    req_msg[0] = m2;
    for (int s = 0; s < 5; s++) begin
      n_total++; if (resp_val[0] !== 1'b1) $display("FAIL bp_val[%0d]: got %b want 1", s, resp_val[0]); else n_pass++;
      n_total++; if (resp_msg[0] !== e) $display("FAIL bp_msg[%0d]: got %h want %h", s, resp_msg[0], e); else n_pass++;
      n_total++; if (req_rdy[0] !== 1'b0) $display("FAIL bp_rdy[%0d]: got %b want 0", s, req_rdy[0]); else n_pass++;
      @(posedge clk); #1;
    end
    resp_rdy[0] = 1'b1;
    n_total++; if (req_rdy[0] !== 1'b0) $display("FAIL bp_fire_rdy: got %b want 0", req_rdy[0]); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (resp_val[0] !== 1'b0) $display("FAIL bp_after_fire_val: got %b want 0", resp_val[0]); else n_pass++;
    n_total++; if (req_rdy[0] !== 1'b1) $display("FAIL bp_after_fire_rdy: got %b want 1", req_rdy[0]); else n_pass++;
    @(posedge clk); #1;
    req_val[0] = 1'b0;
    n_total++; if (resp_val[0] !== 1'b1 || resp_msg[0] !== e2)
      $display("FAIL bp_next_resp: got val %b msg %h want val 1 msg %h", resp_val[0], resp_msg[0], e2); else n_pass++;
    @(posedge clk); #1;
    resp_rdy[0] = 1'b0;
  endtask

  task automatic test_wrap();
    mem_req_4B_t  m;
    mem_resp_4B_t r, e;
    int           lat;
    bit           rl;
    m = mk(3'd1, 8'h61, 32'h1000, 2'd0, 32'h12345678);
    e = model_resp(0, m); send(0, m, r, lat, rl);
    m = mk(3'd0, 8'h62, 32'h0, 2'd0, 32'h0);
    e = model_resp(0, m); send(0, m, r, lat, rl);
    n_total++; if (r.data !== 32'h12345678) $display("FAIL wrap_read: got %h want 12345678", r.data); else n_pass++;
    m = mk(3'd5, 8'h63, 32'h0, 2'd0, 32'hFFFFFFFF);
    e = model_resp(0, m); send(0, m, r, lat, rl);
    n_total++; if (r.data !== 32'd0 || r.type_ !== 3'd5) $display("FAIL unk_type_resp: got %h want type 5 data 0", r); else n_pass++;
    n_total++; if (r !== e) $display("FAIL unk_type_model: got %h want %h", r, e); else n_pass++;
    m = mk(3'd0, 8'h64, 32'h0, 2'd0, 32'h0);
    e = model_resp(0, m); send(0, m, r, lat, rl);
    n_total++; if (r.data !== 32'h12345678) $display("FAIL unk_type_nochange: got %h want 12345678", r.data); else n_pass++;
  endtask

  task automatic test_reset_wait();
    mem_req_4B_t  m;
    mem_resp_4B_t r, e;
    int           lat;
    bit           rl;
    bit           seen;
    m = mk(3'd1, 8'h70, 32'h60, 2'd0, 32'hCAFEF00D);
    e = model_resp(1, m);
    req_msg[1] = m; req_val[1] = 1'b1; resp_rdy[1] = 1'b1;
    @(posedge clk); #1;
    req_val[1] = 1'b0;
    n_total++; if (req_rdy[1] !== 1'b0) $display("FAIL rw_wait_rdy: got %b want 0", req_rdy[1]); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    n_total++; if (resp_val[1] !== 1'b0) $display("FAIL rw_async_val: got %b want 0", resp_val[1]); else n_pass++;
    n_total++; if (req_rdy[1] !== 1'b1) $display("FAIL rw_async_rdy: got %b want 1", req_rdy[1]); else n_pass++;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_val[1] === 1'b1) seen = 1'b1;
    end
    resp_rdy[1] = 1'b0;
    n_total++; if (seen !== 1'b0) $display("FAIL rw_no_resp: got %b want 0", seen); else n_pass++;
    m = mk(3'd0, 8'h71, 32'h60, 2'd0, 32'h0);
    e = model_resp(1, m); send(1, m, r, lat, rl);
    n_total++; if (r.data !== 32'hCAFEF00D) $display("FAIL rw_read: got %h want cafef00d", r.data); else n_pass++;
    n_total++; if (r !== e) $display("FAIL rw_read_resp: got %h want %h", r, e); else n_pass++;
  endtask

  task automatic test_random();
    mem_req_4B_t  m;
    mem_resp_4B_t r, e;
    int           lat;
    bit           rl;
    int           t;
    logic [2:0]   ty;
    logic [31:0]  a;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        m = mk(3'd2, 8'(w), 32'h300 + 32'(4*w), 2'd0, $urandom);
        e = model_resp(d, m); send(d, m, r, lat, rl);
      end
      for (int n = 0; n < 30; n++) begin
        t  = int'($urandom_range(0, 9));
        ty = (t < 4) ? 3'd0 : (t < 6) ? 3'd1 : (t < 8) ? 3'd2 : (t == 8) ? 3'd3 : 3'd7;
        a  = (32'h300 + 32'($urandom_range(0, 63))) | (32'($urandom_range(0, 15)) << 12);
        m  = mk(ty, 8'($urandom), a, 2'($urandom_range(0, 3)), $urandom);
        e  = model_resp(d, m);
        send(d, m, r, lat, rl);
        n_total++; if (r !== e) $display("FAIL rnd_resp[%0d.%0d]: got %h want %h", d, n, r, e); else n_pass++;
        n_total++; if (lat !== 1 + 3*d) $display("FAIL rnd_lat[%0d.%0d]: got %0d want %0d", d, n, lat, 1 + 3*d); else n_pass++;
        n_total++; if (rl !== 1'b1) $display("FAIL rnd_rdy_low[%0d.%0d]: got %b want 1", d, n, rl); else n_pass++;
      end
    end
  endtask

  initial begin
    req_val  = '0;
    resp_rdy = '0;
    req_msg  = '0;
    test_reset();
    test_basic_l0();
    test_latency();
    test_subword();
    test_backpressure();
    test_wrap();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/mem_resp_unit_4b.md
Name: mem_resp_unit_4b

Overview:
- Single-ported, word-organized memory responder for the 4B memory-message interface; it is the responder end of the channel a cache initiates on.
- Accepts one mem_req_4B_t at a time and performs the read, write or init against internal storage.
- Returns one mem_resp_4B_t after a programmable latency.
- Used as backing memory behind the cache in unit and integration benches, and as the simple main-memory model in composed systems.

Parameters:
- NUM_WORDS, 1024, number of 32-bit words stored; must be a power of two.
- LATENCY, 0, extra wait cycles between request accept and response valid (0..15).

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- memreq_val  input  1  request valid.
- memreq_rdy  output  1  responder can accept a request.
- memreq_msg  input  mem_req_4B_t  request: type_, opaque, addr, len, data.
- memresp_val  output  1  response valid.
- memresp_rdy  input  1  initiator can accept the response.
- memresp_msg  output  mem_resp_4B_t  response: type_, opaque, test, len, data.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, memreq_rdy=1, memresp_val=0, latency counter=0, response register=0. Storage contents are not cleared.
- If reset asserts mid-transaction, the pending response is dropped. A write or init already accepted stays committed.
- States: IDLE, WAIT, RESP.
- IDLE: memreq_rdy=1. On fire (memreq_val & memreq_rdy), go to WAIT with counter=LATENCY. If LATENCY==0, go directly to RESP.
- WAIT: memreq_rdy=0. Counter decrements each cycle; on reaching 0, go to RESP.
- RESP: memresp_val=1 and memresp_msg held stable until memresp_rdy. On fire, go to IDLE.
- Timing: request accepted at edge t gives memresp_val=1 from cycle t+1+LATENCY.
- No same-cycle re-accept: memreq_rdy stays 0 in the RESP fire cycle and rises the following cycle.
- Address decode: word index = addr[2+log2(NUM_WORDS)-1:2]. Upper bits are ignored, so addresses wrap modulo NUM_WORDS*4.
- Byte offset = addr[1:0].
- Access size from len: 0 gives 4 bytes; 1, 2, 3 give that many bytes.
- Byte lanes = offset .. offset+size-1. Lanes beyond byte 3 are dropped; there is no cross-word access.
- type_ 0 (read): all work happens at accept. Data is captured from the selected lanes, right-justified and zero-extended. A write accepted earlier is visible to a later read.
- type_ 1 (write) and type_ 2 (init): at accept, write memreq_msg.data low bytes into the selected lanes. Other lanes are unchanged. Response data=0.
- Any other type_: no storage change, response data=0, response still returned.
- Response fields: type_ = request type_; opaque = request opaque; len = request len; test = 0.
- Requests are serviced in order. Exactly one response is returned per accepted request.
- memresp_msg is held constant while memresp_val=1 and memresp_rdy=0; the bench checks this every stalled cycle.

Test Plan:
- LATENCY=0: init addr 0x100 data 0xDEADBEEF, then read 0x100 len 0 -> read resp data 0xDEADBEEF, type_ 0, opaque echoed. Write/init resp data 0. Each resp val exactly 1 cycle after accept.
- LATENCY=3: write 0x40=0x11223344, then read 0x40 -> memresp_val rises 4 cycles after each accept; memreq_rdy low throughout WAIT and RESP.
- Subword: word 0x80=0xAABBCCDD. Write len 1 addr 0x81 data 0x55 -> word becomes 0xAABB55DD. Read len 2 addr 0x82 -> 0x0000AABB.
- Backpressure: hold memresp_rdy=0 for 5 cycles during a read of 0x200 -> memresp_val stays 1, msg unchanged, memreq_rdy stays 0. The next request is accepted only the cycle after the resp fire.
- Wrap: NUM_WORDS=1024. Write addr 0x1000 data 0x12345678, read addr 0x0 -> 0x12345678. Unknown type_ 5 -> resp data 0, type_ 5, no storage change.
- Reset during WAIT (LATENCY=3): after a write accept, pulse reset low -> memresp_val 0 and memreq_rdy 1 immediately. No response is issued. A later read returns the written data.
